// File: rtl/rv32_m_pkg.sv
// Shared RV32M definitions: funct3 encodings, unit state encoding and datapath width.
package rv32_m_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Operand magnitude extraction and result negation shared by the multiply and divide paths.
module md_sign_fix
    import rv32_m_pkg::*;
(
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    input  logic              a_signed,
    input  logic              b_signed,
    input  logic [2*XLEN-1:0] res_raw,
    input  logic              res_neg,
    output logic [XLEN-1:0]   a_mag,
    output logic [XLEN-1:0]   b_mag,
    output logic              a_neg,
    output logic              b_neg,
    output logic [2*XLEN-1:0] res_fixed
);

    assign a_neg = a_signed & op_a[XLEN-1];
    assign b_neg = b_signed & op_b[XLEN-1];

    // 0x80000000 negates to itself, which is the correct unsigned magnitude 2^31
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    assign res_fixed = res_neg ? -res_raw : res_raw;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for an M-op; stalls the front end in the accept cycle
// RUN     | one multiply/divide iteration per edge, counter 0..31
// DONE    | one-cycle result beat to EX/MEM, pipeline released
module ex_muldiv_unit
    import rv32_m_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    md_state_e         state_q, state_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q, rd_out_q;
    logic              neg_q;
    logic [XLEN-1:0]   a_mag_q, b_mag_q, quo_q, rem_q, result_q;
    logic [2*XLEN-1:0] acc_q;

    logic              accept, last_iter;
    logic              a_signed, b_signed, a_neg, b_neg, neg_d;
    logic              div_zero, sgn_ovf, special;
    logic [XLEN-1:0]   a_mag, b_mag, special_res;
    logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
    logic [2*XLEN-1:0] acc_nxt, fix_in, res_fixed;
    logic [XLEN-1:0]   rem_nxt, quo_nxt, res_nxt;

    assign a_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                      (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
    assign b_signed = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    // Remainder takes the dividend's sign; products and quotients the xor of both
    assign neg_d    = (funct3_i == F3_REM) ? a_neg : (a_neg ^ b_neg);

    assign div_zero = funct3_i[2] && (op_b_i == '0);
    assign sgn_ovf  = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                      (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == {XLEN{1'b1}});
    assign special  = div_zero || sgn_ovf;
    assign special_res = funct3_i[1] ? (div_zero ? op_a_i : '0)
                                     : (div_zero ? {XLEN{1'b1}} : {1'b1, {(XLEN-1){1'b0}}});

    md_sign_fix u_sign_fix (
        .op_a      (op_a_i),
        .op_b      (op_b_i),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .res_raw   (fix_in),
        .res_neg   (neg_q),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .res_fixed (res_fixed)
    );

    // Multiplier sits in the low half of acc and shifts out as the product shifts in
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_mag_q};
    assign acc_nxt  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

    // Partial remainder widens to 33 bits for the trial subtract; borrow selects restore
    assign rem_sh   = {rem_q, quo_q[XLEN-1]};
    assign rem_diff = rem_sh - {1'b0, b_mag_q};
    assign rem_nxt  = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
    assign quo_nxt  = {quo_q[XLEN-2:0], ~rem_diff[XLEN]};

    assign fix_in   = !f3_q[2] ? acc_nxt
                    : (f3_q[1] ? {{XLEN{1'b0}}, rem_nxt} : {{XLEN{1'b0}}, quo_nxt});
    assign res_nxt  = (f3_q[2] || (f3_q == F3_MUL)) ? res_fixed[XLEN-1:0]
                                                     : res_fixed[2*XLEN-1:XLEN];

    always_comb begin
        state_nxt = state_q;
        stall_o   = 1'b0;
        done_o    = 1'b0;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    stall_o   = 1'b1;
                    accept    = 1'b1;
                    state_nxt = special ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_q == '1) begin
                    last_iter = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            neg_q    <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            acc_q    <= '0;
        end else if (accept) begin
            cnt_q   <= '0;
            f3_q    <= funct3_i;
            rd_q    <= rd_i;
            neg_q   <= neg_d;
            a_mag_q <= a_mag;
            b_mag_q <= b_mag;
            acc_q   <= {{XLEN{1'b0}}, b_mag};
            rem_q   <= '0;
            quo_q   <= a_mag;
            if (special) begin
                result_q <= special_res;
                rd_out_q <= rd_i;
            end
        end else if (state_q == ST_RUN && !flush_i) begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_nxt;
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            if (last_iter) begin
                result_q <= res_nxt;
                rd_out_q <= rd_q;
            end
        end
    end

    assign result_o = result_q;
    assign rd_o     = rd_out_q;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the registered operands, rd and funct3 when the decoded instruction is an M-extension op.
- Stalls the front of the pipeline while busy, then presents a one-cycle result beat to the EX/MEM register.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.

Parameters:
XLEN, 32, operand/result width (only 32 is supported)
CNT_W, 5, iteration counter width, equal to log2(XLEN)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  M-op valid from ID/EX; sampled only in IDLE
funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a_i  in  32  rs1 value, after forwarding
op_b_i  in  32  rs2 value, after forwarding
rd_i  in  5  destination register
flush_i  in  1  synchronous abort (branch/jump clear)
stall_o  out  1  freeze PC, IF/ID and ID/EX
done_o  out  1  result valid this cycle; doubles as RegWEn
result_o  out  32  rd write data
rd_o  out  5  latched destination register

Behaviour:
- Reset (rst_n low, any time including mid-operation):
  - state IDLE; counter 0.
  - done_o, result_o, rd_o, all internal accumulators 0.
  - No pending result survives reset.
- States:
  - IDLE.
  - RUN: counter 0..31.
  - DONE: exactly one cycle.
- IDLE, start_i=1, flush_i=0 at edge E0:
  - Latch funct3, rd, operand magnitudes and result-sign flag.
  - Signedness: signed for MULH/DIV/REM; op_a signed only for MULHSU; unsigned for MULHU/DIVU/REMU.
  - MUL uses the unsigned low word; its sign does not matter.
  - Special cases go directly to DONE; all others go to RUN with counter=0.
- Special cases, 1-cycle latency, done_o high in the cycle after E0:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- RUN:
  - One iteration per edge; counter increments.
  - The edge at counter==31 performs the final iteration and enters DONE.
  - Total: done_o is high during the 33rd cycle after the start cycle.
- Arithmetic:
  - Multiply uses a 64-bit accumulator.
  - Divide keeps a 33-bit partial remainder and a 32-bit quotient.
  - Sign correction is two's-complement negation of the 64-bit product, quotient or remainder.
  - Remainder sign follows the dividend.
  - MUL returns the low word; MULH* return the high word.
- DONE:
  - done_o=1 and result_o valid; rd_o holds the latched rd.
  - Next state is IDLE.
  - result_o and rd_o hold their value after DONE until the next completion.
- stall_o = (state==IDLE & start_i & ~flush_i) | (state==RUN).
  - stall_o is low in DONE, so the pipeline advances while capturing the result.
- start_i outside IDLE is ignored.
  - The ID/EX register is frozen by stall_o, so start_i stays high during RUN.
  - In DONE, a still-high start_i is not re-accepted.
  - A new start is accepted only in IDLE.
- flush_i=1 in any state:
  - Next state is IDLE; no done_o for the aborted op.
  - result_o and rd_o are unchanged.
  - flush_i has priority over start_i in the same cycle.
- Back-to-back ops:
  - The earliest next acceptance is the cycle after DONE.
  - The bubble is the IDLE cycle.

Decomposition:
- Shared package rv32_m_pkg holds:
  - funct3 constants (F3_MUL .. F3_REMU);
  - state encoding (ST_IDLE, ST_RUN, ST_DONE);
  - XLEN.
- The ID/EX and EX/MEM registers import the same funct3 constants.
- One sub-module is natural: md_sign_fix.
  - Combinational operand-magnitude and result-negation logic, shared by the multiply and divide paths.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3) -> result 0xFFFFFFEB; stall_o high for exactly 33 cycles; done_o pulses once, in cycle 34 counted from the start cycle.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF. rd_o equals the rd given at start.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Each completes with done_o in the cycle after start; stall_o is high only in the start cycle.
- Flush and reset:
  - flush_i pulsed at RUN counter=10 -> IDLE next cycle, stall_o low, no done_o; a fresh DIVU 9/3 is then accepted and gives 3.
  - start and flush together -> not accepted.
  - rst_n low mid-RUN -> all outputs 0 immediately (asynchronous).
